// File: rtl/cdb_pkg.sv
// rtl/cdb_pkg.sv - shared CDB widths, invalid-tag constant and result entry type.
package cdb_pkg;

  localparam int CDB_NUM_REQ = 4;
  localparam int CDB_DATA_W  = 32;
  localparam int CDB_TAG_W   = 5;

  // ROB tags start at 1; tag 0 marks "no result" everywhere on the CDB.
  localparam logic [CDB_TAG_W-1:0] TAG_INVALID = CDB_TAG_W'(0);

  typedef struct packed {
    logic [CDB_TAG_W-1:0]  tag;
    logic [CDB_DATA_W-1:0] data;
    logic                  rd;
  } cdb_entry_t;

endpackage

// File: rtl/cdb_arbiter_if.sv
// rtl/cdb_arbiter_if.sv - execution-unit result handshake and CDB broadcast bundle.
interface cdb_arbiter_if
  import cdb_pkg::*;
#(
  parameter int NUM_REQ = CDB_NUM_REQ,
  parameter int DATA_W  = CDB_DATA_W,
  parameter int TAG_W   = CDB_TAG_W
);

  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0]             req_ready;
  logic [NUM_REQ-1:0][TAG_W-1:0]  req_tag;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]             req_rd;

  logic                           wb_valid;
  logic [TAG_W-1:0]               wb_tag;
  logic [DATA_W-1:0]              wb_data;
  logic                           wb_rd;
  logic [NUM_REQ-1:0]             wb_src;

  modport master (
    output req_valid, req_tag, req_data, req_rd,
    input  req_ready,
    input  wb_valid, wb_tag, wb_data, wb_rd, wb_src
  );

  modport slave (
    input  req_valid, req_tag, req_data, req_rd,
    output req_ready,
    output wb_valid, wb_tag, wb_data, wb_rd, wb_src
  );

endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick: first request at or after ptr.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic               any_grant
);

  int               pos;
  logic [PTR_W-1:0] idx;

  always_comb begin
    grant     = '0;
    any_grant = 1'b0;
    pos       = 0;
    idx       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pos = int'(ptr) + i;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      idx = PTR_W'(pos);
      if (!any_grant && req[idx]) begin
        grant[idx] = 1'b1;
        any_grant  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - per-unit result buffers, round-robin CDB write-back, flush discard.
// CDB_BYPASS_EN lets a result arriving at an empty buffer go straight onto the CDB.
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int NUM_REQ = CDB_NUM_REQ,
  parameter int DATA_W  = CDB_DATA_W,
  parameter int TAG_W   = CDB_TAG_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  cdb_arbiter_if.slave  bus
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [TAG_W-1:0] TAG_NONE = TAG_W'(TAG_INVALID);

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
    logic              rd;
  } entry_t;

  entry_t             buf_q [NUM_REQ];
  entry_t             buf_d [NUM_REQ];
  entry_t             in_entry [NUM_REQ];
  logic [NUM_REQ-1:0] buf_valid_q, buf_valid_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;

  logic               wb_valid_q, wb_valid_d;
  entry_t             wb_q, wb_d;
  logic [NUM_REQ-1:0] wb_src_q, wb_src_d;

  logic [NUM_REQ-1:0] tag_ok, ready, accept, load, cand, grant;
  logic               any_grant;
  logic               do_bcast;
  entry_t             win;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      in_entry[i] = '{tag: bus.req_tag[i], data: bus.req_data[i], rd: bus.req_rd[i]};
      tag_ok[i]   = (bus.req_tag[i] != TAG_NONE);
    end
  end

`ifdef CDB_BYPASS_EN
  // An empty buffer is always ready outside flush, so the input-side candidate
  // is written without req_ready to keep grant out of its own fan-in.
  assign cand = buf_valid_q | (bus.req_valid & tag_ok & ~buf_valid_q & {NUM_REQ{~flush}});
`else
  assign cand = buf_valid_q;
`endif

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr (
    .req       (cand),
    .ptr       (ptr_q),
    .grant     (grant),
    .any_grant (any_grant)
  );

  assign ready         = ~buf_valid_q | grant;
  assign bus.req_ready = ready & {NUM_REQ{~flush}};
  assign accept        = bus.req_valid & bus.req_ready & tag_ok;
  assign do_bcast      = any_grant & ~flush;

`ifdef CDB_BYPASS_EN
  assign load = accept & ~(grant & ~buf_valid_q);
`else
  assign load = accept;
`endif

  always_comb begin
    win   = '0;
    ptr_d = ptr_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        win = buf_valid_q[i] ? buf_q[i] : in_entry[i];
        if (do_bcast) ptr_d = (i == NUM_REQ - 1) ? '0 : PTR_W'(i + 1);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      buf_d[i] = load[i] ? in_entry[i] : buf_q[i];
      if (flush)          buf_valid_d[i] = 1'b0;
      else if (load[i])   buf_valid_d[i] = 1'b1;
      else if (grant[i])  buf_valid_d[i] = 1'b0;
      else                buf_valid_d[i] = buf_valid_q[i];
    end
  end

  // Data and rd keep their last broadcast value while the bus is idle.
  always_comb begin
    wb_valid_d = 1'b0;
    wb_src_d   = '0;
    wb_d       = wb_q;
    wb_d.tag   = TAG_NONE;
    if (do_bcast) begin
      wb_valid_d = 1'b1;
      wb_src_d   = grant;
      wb_d       = win;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_valid_q <= '0;
      ptr_q       <= '0;
      wb_valid_q  <= 1'b0;
      wb_q        <= '{tag: TAG_NONE, data: '0, rd: 1'b0};
      wb_src_q    <= '0;
    end else begin
      buf_valid_q <= buf_valid_d;
      ptr_q       <= ptr_d;
      wb_valid_q  <= wb_valid_d;
      wb_q        <= wb_d;
      wb_src_q    <= wb_src_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) buf_q[i] <= buf_d[i];
  end

  assign bus.wb_valid = wb_valid_q;
  assign bus.wb_tag   = wb_q.tag;
  assign bus.wb_data  = wb_q.data;
  assign bus.wb_rd    = wb_q.rd;
  assign bus.wb_src   = wb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - scoreboard bench: reference model queues expected broadcasts, monitor checks CDB.
module tb_cdb_arbiter;
  import cdb_pkg::*;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int TW = 5;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  always #5 clk = ~clk;

  cdb_arbiter_if #(.NUM_REQ(N), .DATA_W(DW), .TAG_W(TW)) bus ();

  cdb_arbiter #(.NUM_REQ(N), .DATA_W(DW), .TAG_W(TW)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  typedef struct {
    cdb_entry_t   e;
    logic [N-1:0] src;
    int           cyc;
  } exp_t;

  exp_t       sbq[$];
  bit         mv[N];
  cdb_entry_t me[N];
  int         mptr;
  int         edge_n = 0;
  bit         mon_en = 0;
  int         errors = 0;
  int         checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      edge_n++;
      #2;
      if (mon_en && !rst) begin
        if (bus.wb_valid) begin
          check("wb_expected_present", 64'(sbq.size() != 0), 64'd1);
          if (sbq.size() != 0) begin
            exp_t h;
            h = sbq.pop_front();
            check("wb_cycle", 64'(edge_n), 64'(h.cyc));
            check("wb_tag",   64'(bus.wb_tag),  64'(h.e.tag));
            check("wb_data",  64'(bus.wb_data), 64'(h.e.data));
            check("wb_rd",    64'(bus.wb_rd),   64'(h.e.rd));
            check("wb_src",   64'(bus.wb_src),  64'(h.src));
          end
        end else begin
          check("idle_tag", 64'(bus.wb_tag), 64'd0);
          check("idle_src", 64'(bus.wb_src), 64'd0);
          if (sbq.size() != 0 && sbq[0].cyc <= edge_n) begin
            check("wb_missing", 64'(bus.wb_valid), 64'd1);
            void'(sbq.pop_front());
          end
        end
      end
    end
  end

  // One cycle: drive inputs at the falling edge, predict ready and the
  // broadcast produced by the next rising edge from the arbitration rules.
  task automatic step(input logic fl, input logic [N-1:0] v,
                      input logic [N-1:0][TW-1:0] tg, input logic [N-1:0][DW-1:0] dt,
                      input logic [N-1:0] rdv);
    logic [N-1:0] cand, rdy;
    int           k;
    exp_t         x;
    @(negedge clk);
    flush         = fl;
    bus.req_valid = v;
    bus.req_tag   = tg;
    bus.req_data  = dt;
    bus.req_rd    = rdv;
    #1;
    k = -1;
    for (int i = 0; i < N; i++) begin
      cand[i] = mv[i];
`ifdef CDB_BYPASS_EN
      if (v[i] && !fl && tg[i] != 0) cand[i] = 1'b1;
`endif
    end
    for (int j = 0; j < N; j++)
      if (k < 0 && cand[(mptr + j) % N]) k = (mptr + j) % N;
    for (int i = 0; i < N; i++) rdy[i] = !fl && (!mv[i] || k == i);
    check("req_ready", 64'(bus.req_ready), 64'(rdy));
    if (k >= 0 && !fl) begin
      x.e   = mv[k] ? me[k] : '{tag: tg[k], data: dt[k], rd: rdv[k]};
      x.src = N'(1) << k;
      x.cyc = edge_n + 1;
      sbq.push_back(x);
      mptr = (k + 1) % N;
    end
    for (int i = 0; i < N; i++) begin
      if (fl) mv[i] = 0;
      else begin
        if (k == i) mv[i] = 0;
        if (v[i] && rdy[i] && tg[i] != 0 && !(k == i && !cand_was_buf(i))) begin
          mv[i] = 1;
          me[i] = '{tag: tg[i], data: dt[i], rd: rdv[i]};
        end
      end
    end
  endtask

  // Set by step before the buffer update: which requesters held a buffered entry.
  bit held[N];
  function automatic bit cand_was_buf(input int i);
    return held[i];
  endfunction

  task automatic cyc(input logic fl, input logic [N-1:0] v,
                     input logic [N-1:0][TW-1:0] tg, input logic [N-1:0][DW-1:0] dt,
                     input logic [N-1:0] rdv);
    for (int i = 0; i < N; i++) held[i] = mv[i];
    step(fl, v, tg, dt, rdv);
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) cyc(1'b0, '0, '0, '0, '0);
  endtask

  task automatic send(input int r, input logic [TW-1:0] t, input logic [DW-1:0] d, input logic rd1);
    logic [N-1:0][TW-1:0] tg;
    logic [N-1:0][DW-1:0] dt;
    logic [N-1:0]         v, rdv;
    tg = '0; dt = '0; v = '0; rdv = '0;
    tg[r] = t; dt[r] = d; v[r] = 1'b1; rdv[r] = rd1;
    cyc(1'b0, v, tg, dt, rdv);
  endtask

  task automatic rand_cycle(input logic fl, input logic [N-1:0] v);
    logic [N-1:0][TW-1:0] tg;
    logic [N-1:0][DW-1:0] dt;
    logic [N-1:0]         rdv;
    for (int i = 0; i < N; i++) begin
      tg[i]  = ($urandom_range(0, 9) == 0) ? '0 : TW'($urandom_range(1, 31));
      dt[i]  = $urandom;
      rdv[i] = 1'($urandom_range(0, 1));
    end
    cyc(fl, v, tg, dt, rdv);
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) mv[i] = 0;
    mptr = 0;
    sbq.delete();
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    bus.req_valid = '0;
    bus.req_tag   = '0;
    bus.req_data  = '0;
    bus.req_rd    = '0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    check("rst_wb_valid", 64'(bus.wb_valid), 64'd0);
    check("rst_wb_tag",   64'(bus.wb_tag),   64'd0);
    check("rst_wb_data",  64'(bus.wb_data),  64'd0);
    check("rst_wb_rd",    64'(bus.wb_rd),    64'd0);
    check("rst_wb_src",   64'(bus.wb_src),   64'd0);
    check("rst_ready",    64'(bus.req_ready), 64'hF);
    rst = 1'b0;
    mon_en = 1;

    send(2, 5'd5, 32'hDEAD_BEEF, 1'b1);
    idle(3);

    for (int c = 0; c < 12; c++) rand_cycle(1'b0, 4'hF);
    idle(5);

    for (int t = 1; t <= 8; t++) send(1, TW'(t), 32'h1000 + t, 1'b1);
    idle(3);

    cyc(1'b0, 4'b1001, {5'd9, 5'd0, 5'd0, 5'd7}, {32'h33, 32'h0, 32'h0, 32'h11}, 4'b1001);
    cyc(1'b1, 4'b1000, {5'd12, 5'd0, 5'd0, 5'd0}, {32'h44, 32'h0, 32'h0, 32'h0}, 4'b1000);
    idle(2);
    send(3, 5'd13, 32'h5555_AAAA, 1'b0);
    idle(3);

    send(0, 5'd0, 32'hBAD0_BAD0, 1'b1);
    idle(4);

    cyc(1'b0, 4'b0111, {5'd0, 5'd3, 5'd2, 5'd1}, {32'h0, 32'hC3, 32'hC2, 32'hC1}, 4'b0111);
    cyc(1'b0, 4'b0111, {5'd0, 5'd6, 5'd5, 5'd4}, {32'h0, 32'hC6, 32'hC5, 32'hC4}, 4'b0111);
    @(posedge clk);
    #4;
    rst = 1'b1;
    bus.req_valid = '0;
    #1;
    check("arst_wb_valid", 64'(bus.wb_valid), 64'd0);
    check("arst_wb_tag",   64'(bus.wb_tag),   64'd0);
    check("arst_wb_src",   64'(bus.wb_src),   64'd0);
    check("arst_ready",    64'(bus.req_ready), 64'hF);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 5; c++) rand_cycle(1'b0, 4'hF);
    idle(5);

    for (int c = 0; c < 300; c++)
      rand_cycle(($urandom_range(0, 19) == 0), N'($urandom));
    idle(8);
    check("scoreboard_drained", 64'(sbq.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

- Shares the single write-back / common data bus (CDB) among the execution units. The CDB feeds the reservation stations, reg_file and decode-stage forwarding.
- Each execution unit offers results through a valid/ready handshake into a one-entry holding buffer.
- A round-robin arbiter picks one buffered result per cycle and broadcasts it as a registered (tag, data, rd) triple.
- On a branch-mispredict flush, all in-flight results are discarded.

## Interface
Parameters:
- NUM_REQ, 4, number of execution units (requesters)
- DATA_W, 32, result data width
- TAG_W, 5, ROB tag width

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- flush  in  1  synchronous discard of all pending and broadcast results
- req_valid  in  NUM_REQ  requester i presents a result
- req_ready  out  NUM_REQ  requester i result accepted this cycle when valid&ready
- req_tag  in  NUM_REQ×TAG_W  ROB tag per requester
- req_data  in  NUM_REQ×DATA_W  result value per requester
- req_rd  in  NUM_REQ  result writes a register
- wb_valid  out  1  CDB broadcast valid
- wb_tag  out  TAG_W  broadcast tag; TAG_INVALID when wb_valid=0
- wb_data  out  DATA_W  broadcast data
- wb_rd  out  1  broadcast writes register
- wb_src  out  NUM_REQ  one-hot source of current broadcast

## Operation
State:
- Per requester: buf_valid[i] plus a buffered entry (tag, data, rd).
- Round-robin pointer ptr (log2 NUM_REQ bits).
- Registered wb_* outputs.

Accept:
- req_ready[i] = ~flush & (~buf_valid[i] | grant[i]).
- It depends only on state and grant, never on req_valid.
- On valid&ready with req_tag ≠ TAG_INVALID, the entry loads into buf[i] and buf_valid[i] is set.
- A valid&ready request with tag = TAG_INVALID is consumed and dropped.

Arbitrate:
- Candidates are buf_valid[i].
- The grant goes to the first candidate at or after ptr, scanning upward modulo NUM_REQ.
- On a grant to k, ptr ← (k+1) mod NUM_REQ; ptr is unchanged when there is no grant.

Broadcast:
- The winner's entry loads into wb_* at the clock edge, with wb_valid=1 and wb_src one-hot k.
- buf_valid[k] clears unless a new entry loads into it in the same cycle; the new entry then takes the buffer.
- With no grant: wb_valid=0, wb_tag=TAG_INVALID, wb_src=0; wb_data and wb_rd hold their last values.

Flush:
- Next edge: all buf_valid=0 and wb_valid=0.
- req_ready=0 during the flush cycle; nothing is accepted.
- ptr is preserved.

Reset (asynchronous): buf_valid=0, ptr=0, wb_valid=0, wb_tag=TAG_INVALID, wb_data=0, wb_rd=0, wb_src=0.

## Timing
- Uncontended latency: 2 cycles. Accepted at edge t, buffered during t+1, on the CDB (wb_valid=1) during t+2.
- Throughput: one broadcast per cycle total. A single requester sustains one result per cycle (accept and grant overlap).
- Contended: with all NUM_REQ buffers valid, each requester is granted exactly once per NUM_REQ cycles. Worst-case wait is NUM_REQ−1 cycles.
- Flush together with a grant: flush wins and no broadcast follows.
- Flush together with a valid request: the request is not accepted, because req_ready=0.
- Reset deasserted mid-stream: the first accept occurs at the first rising edge after deassertion.

## Configuration
- CDB_BYPASS_EN defined:
  - Candidates become buf_valid[i] | (req_valid[i] & req_ready[i] & tag≠TAG_INVALID).
  - An input-side winner loads directly into wb_* and is not buffered.
  - Uncontended latency: 1 cycle.
  - Buffered entries keep round-robin fairness identical to the undefined case.
  - The ready equation is unchanged.
- Undefined: buffer-only arbitration, 2-cycle latency as above.

## Structure
- Package cdb_pkg:
  - TAG_INVALID = TAG_W'(0); ROB tags start at 1.
  - Typedef cdb_entry_t {tag, data, rd}.
  - Default width constants shared with reg_file and reservation stations.
- Sub-module rr_arbiter: NUM_REQ request vector plus ptr in; one-hot grant and any_grant out; purely combinational.
- ptr register lives in cdb_arbiter.

## Test plan
- Single request: req 2 sends tag=5, data=0xDEAD_BEEF, rd=1 at cycle 0 → wb_valid=1 with those values and wb_src=0100 in cycle 2 (cycle 1 with CDB_BYPASS_EN).
- Full contention: all 4 requesters hold valid continuously from reset → wb_src sequence 0001,0010,0100,1000,0001,…; each requester sees req_ready once per 4 cycles.
- Back-to-back single requester: req 1 streams tags 1..8 every cycle, no contention → req_ready stays 1; tags appear on the CDB in order, one per cycle, 2 cycles delayed.
- Flush: buffers 0 and 3 valid, flush in cycle 4 → wb_valid=0 from cycle 5, both buffers empty, req_ready=0 in cycle 4; a later request from requester 3 broadcasts normally.
- Invalid tag: req 0 sends tag=0 → req_ready=1, no broadcast ever appears.
- Async reset mid-stream: assert rst between edges with 3 buffers valid → wb_valid=0 and wb_tag=0 immediately; after release, first broadcast starts at requester 0 priority.
